// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller for instruction fetch and data load/store.
// Moves 1, 2 or 4 bytes per access over an 8-bit synchronous RAM port and holds the pipeline.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [4:0]        stall_signal_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic [ADDR_W-1:0] next_a_s;
  logic [2:0]        cap_idx_s;
  logic [2:0]        cnt_inc_s;
  logic [31:0]       rd_word_s;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    logic [2:0] len;
    case (size)
      2'd0:    len = 3'd1;
      2'd1:    len = 3'd2;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx[1:0], 3'b000} +: 8];
  endfunction

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    cnt_inc_s = cnt_q + 3'd1;
    cap_idx_s = cnt_q - 3'd1;
    next_a_s  = base_q + ADDR_W'(cnt_inc_s);
    // Byte captured at the end of cycle k lands in lane k-1; lanes beyond N stay zero
    rd_word_s = rbuf_q;
    rd_word_s[{cap_idx_s[1:0], 3'b000} +: 8] = ram_din_i;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          len_d   = size_len(mem_size_i);
          base_d  = mem_addr_i[ADDR_W-1:0];
          ram_a_d = mem_addr_i[ADDR_W-1:0];
          cnt_d   = 3'd0;
          rbuf_d  = 32'h0000_0000;
          wbuf_d  = mem_wdata_i;
          if (mem_we_i) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_i[7:0];
          end else begin
            state_d    = MEM_RD;
          end
        end else if (if_req_i) begin
          state_d = IF_RD;
          len_d   = 3'd4;
          base_d  = if_addr_i[ADDR_W-1:0];
          ram_a_d = if_addr_i[ADDR_W-1:0];
          cnt_d   = 3'd0;
          rbuf_d  = 32'h0000_0000;
        end else begin
          state_d = IDLE;
        end
      end
      IF_RD, MEM_RD: begin
        cnt_d = cnt_inc_s;
        if (cnt_q != 3'd0) begin
          rbuf_d = rd_word_s;
        end else begin
          rbuf_d = rbuf_q;
        end
        if (cnt_inc_s < len_q) begin
          ram_a_d = next_a_s;
        end else begin
          ram_a_d = ram_a_q;
        end
        if (cnt_q == len_q) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          if (state_q == IF_RD) begin
            if_data_d = rd_word_s;
            if_done_d = 1'b1;
          end else begin
            mem_rdata_d = rd_word_s;
            mem_done_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      MEM_WR: begin
        if (cnt_inc_s < len_q) begin
          cnt_d      = cnt_inc_s;
          ram_a_d    = next_a_s;
          ram_dout_d = byte_sel(wbuf_q, cnt_inc_s);
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = DONE;
          cnt_d      = 3'd0;
          mem_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and registered outputs; reset clears RAM strobes immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      base_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= 1'b0;
      wbuf_q      <= 32'h0000_0000;
      rbuf_q      <= 32'h0000_0000;
      if_data_q   <= 32'h0000_0000;
      mem_rdata_q <= 32'h0000_0000;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // Pipeline hold: a data access freezes every stage, a fetch only PC and IF/ID
  always_comb begin
    if (mem_req_i && !mem_done_q) begin
      stall_signal_o = 5'b11111;
    end else if (if_req_i && !if_done_q) begin
      stall_signal_o = 5'b00011;
    end else begin
      stall_signal_o = 5'b00000;
    end
  end

  assign if_data_o   = if_data_q;
  assign if_done_o   = if_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_a_o     = ram_a_q;
  assign ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a synchronous byte RAM model plus per-scenario tasks
// that compare outputs against hand-computed values on the falling edge.
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [16:0] ram_a_o;
  logic        ram_wr_o;
  logic [4:0]  stall_signal_o;

  logic [7:0]  mem [0:131071];
  logic        pre_we;
  logic [16:0] pre_a;
  logic [7:0]  pre_d;

  int checks;
  int errors;

  mem_ctrl #(.ADDR_W(17)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_done_o      (if_done_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_done_o     (mem_done_o),
    .ram_din_i      (ram_din_i),
    .ram_dout_o     (ram_dout_o),
    .ram_a_o        (ram_a_o),
    .ram_wr_o       (ram_wr_o),
    .stall_signal_o (stall_signal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after its address
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (ram_wr_o) begin
      mem[ram_a_o] <= ram_dout_o;
    end
    ram_din_i <= mem[ram_a_o];
  end

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({if_data_o, mem_rdata_o, if_done_o, mem_done_o, ram_wr_o, ram_a_o, ram_dout_o} !== 92'h0) begin
      errors++;
      $display("FAIL reset_outputs: if_data=%h rdata=%h ifd=%b md=%b wr=%b a=%h dout=%h, want all 0",
               if_data_o, mem_rdata_o, if_done_o, mem_done_o, ram_wr_o, ram_a_o, ram_dout_o);
    end
    checks++;
    if (stall_signal_o !== 5'b00000) begin
      errors++;
      $display("FAIL reset_stall: got %b want 00000", stall_signal_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_if_fetch;
    if_addr_i = 32'h0000_0100;
    if_req_i  = 1'b1;
    #1;
    checks++;
    if (stall_signal_o !== 5'b00011) begin
      errors++;
      $display("FAIL if_stall_c0: got %b want 00011", stall_signal_o);
    end
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      checks++;
      if (if_done_o !== (c == 6)) begin
        errors++;
        $display("FAIL if_done_c%0d: got %b want %b", c, if_done_o, (c == 6));
      end
      checks++;
      if (stall_signal_o !== ((c < 6) ? 5'b00011 : 5'b00000)) begin
        errors++;
        $display("FAIL if_stall_c%0d: got %b", c, stall_signal_o);
      end
      if (c == 1) begin
        checks++;
        if (ram_a_o !== 17'h00100) begin
          errors++;
          $display("FAIL if_addr_c1: got %h want 00100", ram_a_o);
        end
      end
    end
    checks++;
    if (if_data_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL if_data: got %h want 00000013", if_data_o);
    end
    if_req_i = 1'b0;
    next_cycle();
    checks++;
    if (if_done_o !== 1'b0 || if_data_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL if_hold: done=%b data=%h want 0/00000013", if_done_o, if_data_o);
    end
  endtask

  task automatic test_store_word;
    logic [31:0] wd;
    wd = 32'hDEAD_BEEF;
    mem_addr_i  = 32'h0000_0020;
    mem_wdata_i = wd;
    mem_size_i  = 2'd2;
    mem_we_i    = 1'b1;
    mem_req_i   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c <= 4) begin
        checks++;
        if (ram_wr_o !== 1'b1 || ram_a_o !== 17'(32'h20 + c - 1) || ram_dout_o !== wd[8*(c-1) +: 8]) begin
          errors++;
          $display("FAIL st_byte_c%0d: wr=%b a=%h d=%h want 1/%h/%h", c, ram_wr_o, ram_a_o, ram_dout_o,
                   17'(32'h20 + c - 1), wd[8*(c-1) +: 8]);
        end
        checks++;
        if (stall_signal_o !== 5'b11111) begin
          errors++;
          $display("FAIL st_stall_c%0d: got %b want 11111", c, stall_signal_o);
        end
      end else begin
        checks++;
        if (ram_wr_o !== 1'b0 || mem_done_o !== 1'b1) begin
          errors++;
          $display("FAIL st_done: wr=%b done=%b want 0/1", ram_wr_o, mem_done_o);
        end
      end
      if (c < 5) begin
        checks++;
        if (mem_done_o !== 1'b0) begin
          errors++;
          $display("FAIL st_early_done_c%0d: got 1 want 0", c);
        end
      end
    end
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    next_cycle();
    checks++;
    if ({mem[17'h23], mem[17'h22], mem[17'h21], mem[17'h20]} !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL st_ram: got %h%h%h%h want deadbeef", mem[17'h23], mem[17'h22], mem[17'h21], mem[17'h20]);
    end
  endtask

  task automatic test_load_half;
    checks++;
    if (mem_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL ld_pre_rdata: got %h want 00000000", mem_rdata_o);
    end
    mem_addr_i = 32'h0000_0031;
    mem_size_i = 2'd1;
    mem_we_i   = 1'b0;
    mem_req_i  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      checks++;
      if (mem_done_o !== (c == 4) || ram_wr_o !== 1'b0) begin
        errors++;
        $display("FAIL ld_done_c%0d: done=%b wr=%b want %b/0", c, mem_done_o, ram_wr_o, (c == 4));
      end
      checks++;
      if (stall_signal_o !== ((c < 4) ? 5'b11111 : 5'b00000)) begin
        errors++;
        $display("FAIL ld_stall_c%0d: got %b", c, stall_signal_o);
      end
      if (c == 2) begin
        checks++;
        if (ram_a_o !== 17'h00032) begin
          errors++;
          $display("FAIL ld_addr_c2: got %h want 00032", ram_a_o);
        end
      end
    end
    checks++;
    if (mem_rdata_o !== 32'h0000_1234) begin
      errors++;
      $display("FAIL ld_half_data: got %h want 00001234", mem_rdata_o);
    end
    mem_req_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back;
    mem_addr_i = 32'h0000_0040;
    mem_size_i = 2'd0;
    mem_we_i   = 1'b0;
    if_addr_i  = 32'h0000_0104;
    mem_req_i  = 1'b1;
    if_req_i   = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      checks++;
      if (mem_done_o !== (c == 3) || if_done_o !== (c == 10)) begin
        errors++;
        $display("FAIL b2b_done_c%0d: md=%b ifd=%b want %b/%b", c, mem_done_o, if_done_o, (c == 3), (c == 10));
      end
      checks++;
      if (stall_signal_o !== ((c < 3) ? 5'b11111 : (c < 10) ? 5'b00011 : 5'b00000)) begin
        errors++;
        $display("FAIL b2b_stall_c%0d: got %b", c, stall_signal_o);
      end
      if (c == 3) begin
        checks++;
        if (mem_rdata_o !== 32'h0000_00A5) begin
          errors++;
          $display("FAIL b2b_mem_data: got %h want 000000a5", mem_rdata_o);
        end
        mem_req_i = 1'b0;
      end
    end
    checks++;
    if (if_data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_if_data: got %h want 12345678", if_data_o);
    end
    if_req_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_addr_wrap;
    mem_addr_i  = 32'h0001_FFFF;
    mem_wdata_i = 32'h1234_565A;
    mem_size_i  = 2'd0;
    mem_we_i    = 1'b1;
    mem_req_i   = 1'b1;
    next_cycle();
    checks++;
    if (ram_wr_o !== 1'b1 || ram_a_o !== 17'h1FFFF || ram_dout_o !== 8'h5A) begin
      errors++;
      $display("FAIL wrap_st: wr=%b a=%h d=%h want 1/1ffff/5a", ram_wr_o, ram_a_o, ram_dout_o);
    end
    next_cycle();
    checks++;
    if (mem_done_o !== 1'b1 || ram_wr_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_st_done: done=%b wr=%b want 1/0", mem_done_o, ram_wr_o);
    end
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    next_cycle();
    mem_size_i = 2'd1;
    mem_req_i  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 2) begin
        checks++;
        if (ram_a_o !== 17'h00000) begin
          errors++;
          $display("FAIL wrap_addr: got %h want 00000", ram_a_o);
        end
      end
    end
    checks++;
    if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h0000_775A) begin
      errors++;
      $display("FAIL wrap_ld: done=%b data=%h want 1/0000775a", mem_done_o, mem_rdata_o);
    end
    mem_req_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_write;
    mem_addr_i  = 32'h0000_0050;
    mem_wdata_i = 32'h1122_3344;
    mem_size_i  = 2'd2;
    mem_we_i    = 1'b1;
    mem_req_i   = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    checks++;
    if (ram_wr_o !== 1'b1 || ram_a_o !== 17'h00052 || ram_dout_o !== 8'h22) begin
      errors++;
      $display("FAIL rst_pre: wr=%b a=%h d=%h want 1/00052/22", ram_wr_o, ram_a_o, ram_dout_o);
    end
    rst_n     = 1'b0;
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    #1;
    checks++;
    if ({if_data_o, mem_rdata_o, if_done_o, mem_done_o, ram_wr_o, ram_a_o, ram_dout_o} !== 92'h0) begin
      errors++;
      $display("FAIL rst_async: if_data=%h rdata=%h ifd=%b md=%b wr=%b a=%h dout=%h, want all 0",
               if_data_o, mem_rdata_o, if_done_o, mem_done_o, ram_wr_o, ram_a_o, ram_dout_o);
    end
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      checks++;
      if (mem_done_o !== 1'b0 || ram_wr_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_hold_c%0d: done=%b wr=%b want 0/0", c, mem_done_o, ram_wr_o);
      end
    end
    rst_n = 1'b1;
    checks++;
    if ({mem[17'h52], mem[17'h51], mem[17'h50]} !== 24'h003344) begin
      errors++;
      $display("FAIL rst_ram: got %h%h%h want 003344", mem[17'h52], mem[17'h51], mem[17'h50]);
    end
    mem_addr_i = 32'h0000_0051;
    mem_size_i = 2'd0;
    mem_req_i  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      checks++;
      if (mem_done_o !== (c == 3)) begin
        errors++;
        $display("FAIL rst_after_done_c%0d: got %b want %b", c, mem_done_o, (c == 3));
      end
    end
    checks++;
    if (mem_rdata_o !== 32'h0000_0033) begin
      errors++;
      $display("FAIL rst_after_data: got %h want 00000033", mem_rdata_o);
    end
    mem_req_i = 1'b0;
    next_cycle();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = 32'h0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_size_i  = 2'd0;
    mem_addr_i  = 32'h0;
    mem_wdata_i = 32'h0;
    pre_we      = 1'b0;
    pre_a       = 17'h0;
    pre_d       = 8'h00;
    @(negedge clk);
    poke(17'h00100, 8'h13);
    poke(17'h00101, 8'h00);
    poke(17'h00102, 8'h00);
    poke(17'h00103, 8'h00);
    poke(17'h00104, 8'h78);
    poke(17'h00105, 8'h56);
    poke(17'h00106, 8'h34);
    poke(17'h00107, 8'h12);
    poke(17'h00031, 8'h34);
    poke(17'h00032, 8'h12);
    poke(17'h00040, 8'hA5);
    poke(17'h00000, 8'h77);
    poke(17'h00052, 8'h00);
    test_reset();
    test_if_fetch();
    test_store_word();
    test_load_half();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
